cva6_tlb_sv32: RTL and testbench

- Fully associative Sv32 translation lookaside buffer (TLB) for the CVA6 MMU. It holds TLB_ENTRIES page table entries (PTEs), each tagged by ASID, VPN and page size.
- Provides a combinational lookup, a single-cycle update (fill) and a selective flush (SFENCE.VMA semantics).
- Exports its raw tag and content arrays for formal equivalence and distinguisher checks.

---
 rtl/cva6_tlb_sv32_pkg.sv | 41 ++++
 rtl/cva6_tlb_plru.sv | 57 +++++
 rtl/cva6_tlb_sv32.sv | 177 +++++++++++++++++
 tb/tb_cva6_tlb_sv32.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_tlb_sv32_pkg.sv
// Shared types for the Sv32 TLB: stored tag, raw Sv32 PTE and fill record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cva6_tlb_sv32_pkg;

    localparam int VPN_W        = 10;
    localparam int ASID_STORE_W = 9;

    // Stored tag, 31 bits; valid sits at bit 0.
    typedef struct packed {
        logic [ASID_STORE_W-1:0] asid;   // [30:22]
        logic [VPN_W-1:0]        vpn1;   // [21:12]
        logic [VPN_W-1:0]        vpn0;   // [11:2]
        logic                    is_4M;  // [1]
        logic                    valid;  // [0]
    } tlb_tag_t;

    // Raw Sv32 page table entry.
    typedef struct packed {
        logic [21:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_sv32_t;

    // Fill record as presented on update_i (63 bits).
    typedef struct packed {
        logic                    valid;    // [62]
        logic                    is_4M;    // [61]
        logic [2*VPN_W-1:0]      vpn;      // [60:41]
        logic [ASID_STORE_W-1:0] asid;     // [40:32]
        pte_sv32_t               content;  // [31:0]
    } tlb_update_t;

endpackage

// File: rtl/cva6_tlb_plru.sv
// Tree pseudo-LRU over ENTRIES ways: one-hot touch in, one-hot victim out.
// Latency: victim is combinational from state; a touch updates state on the next clk_i edge.
// Backpressure: none, a touch is always accepted.
//   Ports: clk_i, rst_i (sync, active-high), touch_i (one-hot way just used), victim_o (one-hot LRU way).
module cva6_tlb_plru #(
    parameter int unsigned ENTRIES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ENTRIES-1:0] touch_i,
    output logic [ENTRIES-1:0] victim_o
);

    localparam int unsigned LOG_N = $clog2(ENTRIES);
    localparam int unsigned IDX_W = (ENTRIES > 2) ? $clog2(ENTRIES - 1) : 1;

    // Node k at level l lives at index (2^l - 1 + k). A node value of 1 means
    // the least-recently-used side is the upper (right) subtree.
    logic [ENTRIES-2:0] tree_q;
    logic [ENTRIES-2:0] tree_d;

    // Touching a way points every node on its path away from it.
    always_comb begin
        tree_d = tree_q;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (touch_i[i]) begin
                for (int unsigned l = 0; l < LOG_N; l++) begin
                    tree_d[IDX_W'((1 << l) - 1 + (i >> (LOG_N - l)))] = ~1'(i >> (LOG_N - l - 1));
                end
            end
        end
    end

    // A way is the victim when every node on its path points towards it.
    always_comb begin
        victim_o = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            victim_o[i] = 1'b1;
            for (int unsigned l = 0; l < LOG_N; l++) begin
                if (1'(i >> (LOG_N - l - 1))) begin
                    victim_o[i] = victim_o[i] & tree_q[IDX_W'((1 << l) - 1 + (i >> (LOG_N - l)))];
                end else begin
                    victim_o[i] = victim_o[i] & ~tree_q[IDX_W'((1 << l) - 1 + (i >> (LOG_N - l)))];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tree_q <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end

endmodule

// File: rtl/cva6_tlb_sv32.sv
// Fully associative Sv32 TLB: combinational lookup, one-edge fill, SFENCE.VMA-style selective flush.
// Latency: lookup 0 cycles; fill and flush take effect on the next clk_i edge.
// Backpressure: none; a flush in the same cycle as a fill wins and the fill is dropped.
//   Ports: clk_i, rst_ni (sync, active-high), flush_i + asid/vaddr_to_be_flushed_i, update_i fill record,
//   lu_* lookup request/result, port_tags_q_o / port_content_q_o raw arrays (entry i at [31i+:31] / [32i+:32]).
//   Build option: define TLB_GLOBAL_PAGE_EN to honour the PTE g bit on lookup and ASID-qualified flush.
module cva6_tlb_sv32
    import cva6_tlb_sv32_pkg::*;
#(
    parameter int unsigned TLB_ENTRIES = 4,
    parameter int unsigned ASID_WIDTH  = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [62:0]               update_i,
    input  logic                      lu_access_i,
    input  logic [ASID_WIDTH-1:0]     lu_asid_i,
    input  logic [31:0]               lu_vaddr_i,
    output logic [31:0]               lu_content_o,
    input  logic [ASID_WIDTH-1:0]     asid_to_be_flushed_i,
    input  logic [31:0]               vaddr_to_be_flushed_i,
    output logic                      lu_is_4M_o,
    output logic                      lu_hit_o,
    output logic [32*TLB_ENTRIES-1:0] port_content_q_o,
    output logic [31*TLB_ENTRIES-1:0] port_tags_q_o
);

`ifdef TLB_GLOBAL_PAGE_EN
    localparam bit GLOBAL_EN = 1'b1;
`else
    localparam bit GLOBAL_EN = 1'b0;
`endif

    tlb_tag_t    tags_q    [TLB_ENTRIES];
    pte_sv32_t   content_q [TLB_ENTRIES];
    tlb_update_t upd;

    logic [TLB_ENTRIES-1:0] lu_hit;
    logic [TLB_ENTRIES-1:0] hit_oh;
    logic [TLB_ENTRIES-1:0] invalid_oh;
    logic [TLB_ENTRIES-1:0] plru_victim;
    logic [TLB_ENTRIES-1:0] replace_oh;
    logic [TLB_ENTRIES-1:0] flush_hit;
    logic [TLB_ENTRIES-1:0] touch;
    logic                   any_invalid;
    logic                   upd_en;
    logic                   flush_asid_zero;
    logic                   flush_vaddr_zero;
    logic                   vpn_match;
    logic                   asid_match;
    logic                   g_keep;
    logic                   unused_lu_offset;

    assign upd              = update_i;
    assign upd_en           = upd.valid & ~flush_i;
    assign unused_lu_offset = ^lu_vaddr_i[11:0];

    // Per-entry match; a 4M entry ignores vpn0.
    always_comb begin
        lu_hit = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            lu_hit[i] = tags_q[i].valid
                     && (tags_q[i].vpn1 == lu_vaddr_i[31:22])
                     && (tags_q[i].is_4M || (tags_q[i].vpn0 == lu_vaddr_i[21:12]))
                     && ((tags_q[i].asid[ASID_WIDTH-1:0] == lu_asid_i) || (GLOBAL_EN && content_q[i].g));
        end
    end

    // Scan from the top down so the lowest-index hit is the one left standing.
    always_comb begin
        hit_oh       = '0;
        lu_hit_o     = 1'b0;
        lu_is_4M_o   = 1'b0;
        lu_content_o = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (lu_hit[i]) begin
                hit_oh       = '0;
                hit_oh[i]    = 1'b1;
                lu_hit_o     = 1'b1;
                lu_is_4M_o   = tags_q[i].is_4M;
                lu_content_o = content_q[i];
            end
        end
    end

    // Free slots are filled lowest-first before the PLRU victim is consulted.
    always_comb begin
        invalid_oh  = '0;
        any_invalid = 1'b0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (!tags_q[i].valid) begin
                invalid_oh    = '0;
                invalid_oh[i] = 1'b1;
                any_invalid   = 1'b1;
            end
        end
        replace_oh = any_invalid ? invalid_oh : plru_victim;
    end

    // Zero ASID / zero vaddr act as wildcards. Global entries survive
    // ASID-qualified flushes only when global pages are enabled.
    assign flush_asid_zero  = (asid_to_be_flushed_i == '0);
    assign flush_vaddr_zero = (vaddr_to_be_flushed_i == '0);

    always_comb begin
        flush_hit  = '0;
        vpn_match  = 1'b0;
        asid_match = 1'b0;
        g_keep     = 1'b0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            vpn_match  = (tags_q[i].vpn1 == vaddr_to_be_flushed_i[31:22])
                      && (tags_q[i].is_4M || (tags_q[i].vpn0 == vaddr_to_be_flushed_i[21:12]));
            asid_match = (tags_q[i].asid[ASID_WIDTH-1:0] == asid_to_be_flushed_i);
            g_keep     = GLOBAL_EN && content_q[i].g;
            case ({flush_asid_zero, flush_vaddr_zero})
                2'b11:   flush_hit[i] = 1'b1;
                2'b10:   flush_hit[i] = vpn_match;
                2'b01:   flush_hit[i] = asid_match && !g_keep;
                default: flush_hit[i] = vpn_match && asid_match && !g_keep;
            endcase
        end
    end

    // A fill always marks its own slot most-recent; otherwise a qualified hit does.
    always_comb begin
        touch = '0;
        if (upd_en) begin
            touch = replace_oh;
        end else if (lu_access_i && lu_hit_o) begin
            touch = hit_oh;
        end
    end

    cva6_tlb_plru #(
        .ENTRIES (TLB_ENTRIES)
    ) u_plru (
        .clk_i    (clk_i),
        .rst_i    (rst_ni),
        .touch_i  (touch),
        .victim_o (plru_victim)
    );

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                tags_q[i]    <= '0;
                content_q[i] <= '0;
            end
        end else if (flush_i) begin
            // Only valid bits are dropped; tag and PTE stay visible on the ports.
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                if (flush_hit[i]) begin
                    tags_q[i].valid <= 1'b0;
                end
            end
        end else if (upd_en) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                if (replace_oh[i]) begin
                    // vpn1 holds the upper VPN half so it lines up with vaddr[31:22].
                    tags_q[i].asid  <= upd.asid;
                    tags_q[i].vpn1  <= upd.vpn[19:10];
                    tags_q[i].vpn0  <= upd.vpn[9:0];
                    tags_q[i].is_4M <= upd.is_4M;
                    tags_q[i].valid <= 1'b1;
                    content_q[i]    <= upd.content;
                end
            end
        end
    end

    for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_port
        assign port_tags_q_o[31*i +: 31]    = tags_q[i];
        assign port_content_q_o[32*i +: 32] = content_q[i];
    end

endmodule

// File: tb/tb_cva6_tlb_sv32.sv
// Self-checking bench for cva6_tlb_sv32: expected lookup results are queued when a lookup is driven
// and popped for comparison once the outputs have settled; array and valid-bit checks are inline.
// Honours TLB_GLOBAL_PAGE_EN the same way as the design build.
module tb_cva6_tlb_sv32;

    localparam int N  = 4;
    localparam int AW = 1;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b1;
    logic            flush_i = 1'b0;
    logic [62:0]     update_i = '0;
    logic            lu_access_i = 1'b0;
    logic [AW-1:0]   lu_asid_i = '0;
    logic [31:0]     lu_vaddr_i = '0;
    logic [31:0]     lu_content_o;
    logic [AW-1:0]   asid_to_be_flushed_i = '0;
    logic [31:0]     vaddr_to_be_flushed_i = '0;
    logic            lu_is_4M_o;
    logic            lu_hit_o;
    logic [32*N-1:0] port_content_q_o;
    logic [31*N-1:0] port_tags_q_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        hit;
        logic        is4m;
        logic [31:0] cont;
    } exp_t;

    exp_t exp_q[$];

    cva6_tlb_sv32 #(.TLB_ENTRIES(N), .ASID_WIDTH(AW)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .update_i              (update_i),
        .lu_access_i           (lu_access_i),
        .lu_asid_i             (lu_asid_i),
        .lu_vaddr_i            (lu_vaddr_i),
        .lu_content_o          (lu_content_o),
        .asid_to_be_flushed_i  (asid_to_be_flushed_i),
        .vaddr_to_be_flushed_i (vaddr_to_be_flushed_i),
        .lu_is_4M_o            (lu_is_4M_o),
        .lu_hit_o              (lu_hit_o),
        .port_content_q_o      (port_content_q_o),
        .port_tags_q_o         (port_tags_q_o)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_reset();
        rst_ni = 1'b1; flush_i = 1'b0; update_i = '0; lu_access_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b0;
    endtask

    task automatic do_update(input logic [19:0] vpn, input logic [8:0] asid,
                             input logic is4m, input logic [31:0] cont);
        update_i = {1'b1, is4m, vpn, asid, cont};
        @(posedge clk);
        #1 update_i = '0;
    endtask

    task automatic do_flush(input logic [AW-1:0] asid, input logic [31:0] va);
        flush_i = 1'b1; asid_to_be_flushed_i = asid; vaddr_to_be_flushed_i = va;
        @(posedge clk);
        #1 flush_i = 1'b0;
    endtask

    task automatic drive_lookup(input logic [31:0] va, input logic [AW-1:0] asid, input exp_t e);
        lu_vaddr_i = va;
        lu_asid_i  = asid;
        exp_q.push_back(e);
    endtask

    function automatic logic [3:0] valid_bits();
        return {port_tags_q_o[93], port_tags_q_o[62], port_tags_q_o[31], port_tags_q_o[0]};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        exp_t e;
        do_reset();
        do_update(20'h00777, 9'd0, 1'b0, 32'h0000_000F);
        checks++;
        if (port_tags_q_o[0] !== 1'b1) begin
            failures++; $display("FAIL reset_prefill_valid: got %b want 1", port_tags_q_o[0]);
        end
        // Reset held during a simultaneous flush and fill must still clear everything.
        rst_ni = 1'b1; flush_i = 1'b1; update_i = {1'b1, 1'b0, 20'h00888, 9'd0, 32'h0000_000F};
        @(posedge clk);
        #1 rst_ni = 1'b0; flush_i = 1'b0; update_i = '0;
        checks++;
        if (port_tags_q_o !== '0) begin
            failures++; $display("FAIL reset_tags: got %h want 0", port_tags_q_o);
        end
        checks++;
        if (port_content_q_o !== '0) begin
            failures++; $display("FAIL reset_content: got %h want 0", port_content_q_o);
        end
        drive_lookup(32'h0000_0000, 1'b0, {1'b0, 1'b0, 32'h0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({lu_hit_o, lu_is_4M_o, lu_content_o} !== e) begin
            failures++;
            $display("FAIL reset_lookup: got hit=%b 4M=%b pte=%h want hit=%b 4M=%b pte=%h",
                     lu_hit_o, lu_is_4M_o, lu_content_o, e.hit, e.is4m, e.cont);
        end
    endtask

    task automatic test_fill();
        logic [31:0]   va [5];
        logic [AW-1:0] as [5];
        exp_t          ex [5];
        exp_t          e;
        do_reset();
        do_update(20'h12345, 9'd1, 1'b0, 32'h0000_0C0F);
        checks++;
        if (port_tags_q_o[30:0] !== {9'd1, 10'h048, 10'h345, 1'b0, 1'b1}) begin
            failures++; $display("FAIL fill_tag: got %h want %h", port_tags_q_o[30:0],
                                 {9'd1, 10'h048, 10'h345, 1'b0, 1'b1});
        end
        checks++;
        if (port_content_q_o[31:0] !== 32'h0000_0C0F) begin
            failures++; $display("FAIL fill_content: got %h want 00000c0f", port_content_q_o[31:0]);
        end
        va = '{32'h1234_5000, 32'h1234_5FFF, 32'h1234_5000, 32'h1234_6000, 32'h1274_5000};
        as = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ex = '{{1'b1, 1'b0, 32'h0000_0C0F}, {1'b1, 1'b0, 32'h0000_0C0F},
               {1'b0, 1'b0, 32'h0}, {1'b0, 1'b0, 32'h0}, {1'b0, 1'b0, 32'h0}};
        for (int k = 0; k < 5; k++) begin
            drive_lookup(va[k], as[k], ex[k]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({lu_hit_o, lu_is_4M_o, lu_content_o} !== e) begin
                failures++;
                $display("FAIL fill_lookup[%0d]: got hit=%b 4M=%b pte=%h want hit=%b 4M=%b pte=%h",
                         k, lu_hit_o, lu_is_4M_o, lu_content_o, e.hit, e.is4m, e.cont);
            end
        end
    endtask

    task automatic test_plru();
        logic [19:0] vpn [6];
        logic [31:0] va [6];
        exp_t        ex [6];
        exp_t        e;
        vpn = '{20'h00100, 20'h00200, 20'h00300, 20'h00400, 20'h00500, 20'h00600};
        do_reset();
        for (int i = 0; i < 4; i++) do_update(vpn[i], 9'd0, 1'b0, {20'(i + 1), 12'h00F});
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (port_tags_q_o[31*i+2 +: 20] !== vpn[i]) begin
                failures++; $display("FAIL plru_fill_order[%0d]: got vpn %h want %h",
                                     i, port_tags_q_o[31*i+2 +: 20], vpn[i]);
            end
        end
        // All full, tree says way 0 is oldest.
        do_update(vpn[4], 9'd0, 1'b0, {20'd5, 12'h00F});
        checks++;
        if (port_tags_q_o[2 +: 20] !== vpn[4]) begin
            failures++; $display("FAIL plru_victim0: got vpn %h want %h", port_tags_q_o[2 +: 20], vpn[4]);
        end
        // Access-hit way 2; the next victim moves to way 1.
        lu_vaddr_i = {vpn[2], 12'h0}; lu_asid_i = 1'b0; lu_access_i = 1'b1;
        @(posedge clk);
        #1 lu_access_i = 1'b0;
        do_update(vpn[5], 9'd0, 1'b0, {20'd6, 12'h00F});
        checks++;
        if (port_tags_q_o[31+2 +: 20] !== vpn[5]) begin
            failures++; $display("FAIL plru_victim1: got vpn %h want %h", port_tags_q_o[31+2 +: 20], vpn[5]);
        end
        for (int k = 0; k < 6; k++) va[k] = {vpn[k], 12'h0};
        ex = '{{1'b0, 1'b0, 32'h0}, {1'b0, 1'b0, 32'h0}, {1'b1, 1'b0, {20'd3, 12'h00F}},
               {1'b1, 1'b0, {20'd4, 12'h00F}}, {1'b1, 1'b0, {20'd5, 12'h00F}},
               {1'b1, 1'b0, {20'd6, 12'h00F}}};
        for (int k = 0; k < 6; k++) begin
            drive_lookup(va[k], 1'b0, ex[k]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({lu_hit_o, lu_is_4M_o, lu_content_o} !== e) begin
                failures++;
                $display("FAIL plru_lookup[%0d]: got hit=%b 4M=%b pte=%h want hit=%b 4M=%b pte=%h",
                         k, lu_hit_o, lu_is_4M_o, lu_content_o, e.hit, e.is4m, e.cont);
            end
        end
    endtask

    task automatic test_4m();
        logic [31:0] va [3];
        exp_t        ex [3];
        exp_t        e;
        do_reset();
        do_update(20'h40000, 9'd0, 1'b1, 32'h2000_00CF);
        va = '{32'h400A_B000, 32'h403F_F000, 32'h404A_B000};
        ex = '{{1'b1, 1'b1, 32'h2000_00CF}, {1'b1, 1'b1, 32'h2000_00CF}, {1'b0, 1'b0, 32'h0}};
        for (int k = 0; k < 3; k++) begin
            drive_lookup(va[k], 1'b0, ex[k]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({lu_hit_o, lu_is_4M_o, lu_content_o} !== e) begin
                failures++;
                $display("FAIL mega_lookup[%0d]: got hit=%b 4M=%b pte=%h want hit=%b 4M=%b pte=%h",
                         k, lu_hit_o, lu_is_4M_o, lu_content_o, e.hit, e.is4m, e.cont);
            end
        end
    endtask

    task automatic test_flush_all();
        logic [19:0] vpn [4];
        exp_t        e;
        vpn = '{20'h00011, 20'h00022, 20'h00033, 20'h00044};
        do_reset();
        for (int i = 0; i < 4; i++) do_update(vpn[i], 9'd0, 1'b0, {20'(i + 8), 12'h00F});
        do_flush(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (port_tags_q_o[31*i] !== 1'b0) begin
                failures++; $display("FAIL flush_all_valid[%0d]: got %b want 0", i, port_tags_q_o[31*i]);
            end
            checks++;
            if (port_tags_q_o[31*i+1 +: 30] !== {9'd0, vpn[i], 1'b0}) begin
                failures++; $display("FAIL flush_all_tag_kept[%0d]: got %h want %h",
                                     i, port_tags_q_o[31*i+1 +: 30], {9'd0, vpn[i], 1'b0});
            end
            checks++;
            if (port_content_q_o[32*i +: 32] !== {20'(i + 8), 12'h00F}) begin
                failures++; $display("FAIL flush_all_content[%0d]: got %h want %h",
                                     i, port_content_q_o[32*i +: 32], {20'(i + 8), 12'h00F});
            end
        end
        drive_lookup(32'h0001_1000, 1'b0, {1'b0, 1'b0, 32'h0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({lu_hit_o, lu_is_4M_o, lu_content_o} !== e) begin
            failures++;
            $display("FAIL flush_all_lookup: got hit=%b 4M=%b pte=%h want hit=%b 4M=%b pte=%h",
                     lu_hit_o, lu_is_4M_o, lu_content_o, e.hit, e.is4m, e.cont);
        end
    endtask

    task automatic test_flush_select();
        exp_t       e;
        logic [3:0] want;
        do_reset();
        do_update(20'h00011, 9'd1, 1'b0, 32'h0000_100F);
        do_update(20'h00022, 9'd0, 1'b0, 32'h0000_200F);
        do_update(20'h40000, 9'd1, 1'b1, 32'h0000_300F);
        do_update(20'h00033, 9'd1, 1'b0, 32'h0000_402F);  // global page
`ifdef TLB_GLOBAL_PAGE_EN
        drive_lookup(32'h0003_3000, 1'b0, {1'b1, 1'b0, 32'h0000_402F});
`else
        drive_lookup(32'h0003_3000, 1'b0, {1'b0, 1'b0, 32'h0});
`endif
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({lu_hit_o, lu_is_4M_o, lu_content_o} !== e) begin
            failures++;
            $display("FAIL global_lookup: got hit=%b 4M=%b pte=%h want hit=%b 4M=%b pte=%h",
                     lu_hit_o, lu_is_4M_o, lu_content_o, e.hit, e.is4m, e.cont);
        end
        do_flush(1'b0, 32'h4012_3000);   // any ASID, matches the megapage by vpn1
        checks++;
        if (valid_bits() !== 4'b1011) begin
            failures++; $display("FAIL flush_vaddr: got valid %b want 1011", valid_bits());
        end
        do_flush(1'b1, 32'h0001_1000);   // ASID and VPN
        checks++;
        if (valid_bits() !== 4'b1010) begin
            failures++; $display("FAIL flush_asid_vaddr: got valid %b want 1010", valid_bits());
        end
        do_flush(1'b1, 32'h0);           // ASID only
`ifdef TLB_GLOBAL_PAGE_EN
        want = 4'b1010;
`else
        want = 4'b0010;
`endif
        checks++;
        if (valid_bits() !== want) begin
            failures++; $display("FAIL flush_asid: got valid %b want %b", valid_bits(), want);
        end
    endtask

    task automatic test_flush_update();
        exp_t e;
        do_reset();
        do_update(20'h00055, 9'd0, 1'b0, 32'h0000_A00F);
        do_update(20'h00055, 9'd0, 1'b0, 32'h0000_B00F);
        drive_lookup(32'h0005_5000, 1'b0, {1'b1, 1'b0, 32'h0000_A00F});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({lu_hit_o, lu_is_4M_o, lu_content_o} !== e) begin
            failures++;
            $display("FAIL multi_hit_lowest: got hit=%b 4M=%b pte=%h want hit=%b 4M=%b pte=%h",
                     lu_hit_o, lu_is_4M_o, lu_content_o, e.hit, e.is4m, e.cont);
        end
        flush_i = 1'b1; asid_to_be_flushed_i = 1'b0; vaddr_to_be_flushed_i = 32'h0;
        update_i = {1'b1, 1'b0, 20'h00066, 9'd0, 32'h0000_C00F};
        @(posedge clk);
        #1 flush_i = 1'b0; update_i = '0;
        checks++;
        if (valid_bits() !== 4'b0000) begin
            failures++; $display("FAIL flush_update_valid: got valid %b want 0000", valid_bits());
        end
        checks++;
        if (port_tags_q_o[62 +: 31] !== 31'd0) begin
            failures++; $display("FAIL flush_update_dropped: got entry2 tag %h want 0", port_tags_q_o[62 +: 31]);
        end
        drive_lookup(32'h0006_6000, 1'b0, {1'b0, 1'b0, 32'h0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({lu_hit_o, lu_is_4M_o, lu_content_o} !== e) begin
            failures++;
            $display("FAIL flush_update_lookup: got hit=%b 4M=%b pte=%h want hit=%b 4M=%b pte=%h",
                     lu_hit_o, lu_is_4M_o, lu_content_o, e.hit, e.is4m, e.cont);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_plru();
        test_4m();
        test_flush_all();
        test_flush_select();
        test_flush_update();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
